// File: rtl/alu_serial_rx_decoder.sv
// Receive side of the ALU serial link: deframes sin, assembles {B,A}, validates the command packet
// and hands one decoded request to the ALU core over valid/ready. Optional timeout: ALU_RX_TIMEOUT_EN.
module alu_serial_rx_decoder #(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_a,
  output logic [31:0] req_b,
  output logic [2:0]  req_op,
  output logic [2:0]  req_err,
  output logic        frame_err,
  output logic        overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TYPE = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  // Serial CRC4, poly x^4+x+1, init 0, MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        is_cmd_q, is_cmd_d;
  logic [7:0]  shift_q, shift_d;
  logic [63:0] ba_q, ba_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_a_q, req_a_d;
  logic [31:0] req_b_q, req_b_d;
  logic [2:0]  req_op_q, req_op_d;
  logic [2:0]  req_err_q, req_err_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_crc;
  logic [2:0]  cmd_err;

`ifdef ALU_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign cmd_op  = shift_q[6:4];
  assign cmd_crc = shift_q[3:0];

  // Exclusive error code, priority data > crc > op; legal ops are 000,001,100,101 (op[1]==0).
  always_comb begin
    cmd_err = 3'b000;
    if (byte_cnt_q != 4'd8)                       cmd_err = 3'b100;
    else if (cmd_crc != crc4({ba_q, 1'b1, cmd_op})) cmd_err = 3'b010;
    else if (cmd_op[1])                           cmd_err = 3'b001;
  end

  // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    is_cmd_d    = is_cmd_q;
    shift_d     = shift_q;
    ba_d        = ba_q;
    byte_cnt_d  = byte_cnt_q;
    req_valid_d = req_valid_q;
    req_a_d     = req_a_q;
    req_b_d     = req_b_q;
    req_op_d    = req_op_q;
    req_err_d   = req_err_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef ALU_RX_TIMEOUT_EN
    to_cnt_d    = '0;
`endif

    if (req_valid_q && req_ready) begin
      req_valid_d = 1'b0;
      req_a_d     = '0;
      req_b_d     = '0;
      req_op_d    = '0;
      req_err_d   = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (!sin) begin
          state_d = S_TYPE;
        end
`ifdef ALU_RX_TIMEOUT_EN
        else if (byte_cnt_q != 4'd0 && byte_cnt_q <= 4'd8) begin
          if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) byte_cnt_d = 4'd0;
          else                                       to_cnt_d   = to_cnt_q + 1'b1;
        end
`endif
      end
      S_TYPE: begin
        is_cmd_d  = sin;
        bit_cnt_d = 3'd7;
        state_d   = S_DATA;
      end
      S_DATA: begin
        shift_d   = {shift_q[6:0], sin};
        bit_cnt_d = bit_cnt_q - 3'd1;
        if (bit_cnt_q == 3'd0) state_d = S_STOP;
      end
      default: begin
        state_d = S_IDLE;
        if (!sin) begin
          frame_err_d = 1'b1;
        end else if (!is_cmd_q) begin
          ba_d = {ba_q[55:0], shift_q};
          if (byte_cnt_q != 4'd9) byte_cnt_d = byte_cnt_q + 4'd1;
        end else begin
          byte_cnt_d = 4'd0;
          // A held request not taken this cycle wins; the new one is dropped.
          if (req_valid_q && !req_ready) begin
            overrun_d = 1'b1;
          end else begin
            req_valid_d = 1'b1;
            req_b_d     = ba_q[63:32];
            req_a_d     = ba_q[31:0];
            req_op_d    = cmd_op;
            req_err_d   = cmd_err;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      is_cmd_q    <= 1'b0;
      shift_q     <= '0;
      ba_q        <= '0;
      byte_cnt_q  <= '0;
      req_valid_q <= 1'b0;
      req_a_q     <= '0;
      req_b_q     <= '0;
      req_op_q    <= '0;
      req_err_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ALU_RX_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      is_cmd_q    <= is_cmd_d;
      shift_q     <= shift_d;
      ba_q        <= ba_d;
      byte_cnt_q  <= byte_cnt_d;
      req_valid_q <= req_valid_d;
      req_a_q     <= req_a_d;
      req_b_q     <= req_b_d;
      req_op_q    <= req_op_d;
      req_err_q   <= req_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef ALU_RX_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign req_valid = req_valid_q;
  assign req_a     = req_a_q;
  assign req_b     = req_b_q;
  assign req_op    = req_op_q;
  assign req_err   = req_err_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_alu_serial_rx_decoder.sv
// Self-checking bench for alu_serial_rx_decoder: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic and random req_ready.
module tb_alu_serial_rx_decoder;

  localparam int EV_NONE = 0;
  localparam int EV_DATA = 1;
  localparam int EV_CMD  = 2;
  localparam int EV_FERR = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic        req_ready = 1'b0;
  logic        req_valid;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_op, req_err;
  logic        frame_err, overrun;

  always #5 clk = ~clk;

  alu_serial_rx_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_err   (req_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: bytes received since the last command, and the expected outputs.
  logic [7:0]  rx_bytes[$];
  int          rx_cnt;
  bit          m_valid, m_fe, m_ov;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op, m_err;
  int          fe_seen = 0;
  int          ov_seen = 0;
  bit          rnd_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // CRC as the remainder of ({B,A,1,op} * x^4) divided by x^4+x+1.
  function automatic logic [3:0] crc_ref(input logic [31:0] b, input logic [31:0] a,
                                         input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  task automatic model_reset();
    rx_bytes.delete();
    rx_cnt  = 0;
    m_valid = 1'b0;
    m_a = '0; m_b = '0; m_op = '0; m_err = '0;
    m_fe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic model_edge(input int kind, input logic [7:0] by);
    bit          busy;
    logic [31:0] a, b;
    logic [2:0]  op, err;
    busy = m_valid && !req_ready;
    m_fe = 1'b0;
    m_ov = 1'b0;
    if (m_valid && req_ready) begin
      m_valid = 1'b0;
      m_a = '0; m_b = '0; m_op = '0; m_err = '0;
    end
    if (kind == EV_DATA) begin
      rx_bytes.push_back(by);
      if (rx_bytes.size() > 8) void'(rx_bytes.pop_front());
      if (rx_cnt < 9) rx_cnt++;
    end else if (kind == EV_FERR) begin
      m_fe = 1'b1;
    end else if (kind == EV_CMD) begin
      op = by[6:4];
      a = '0;
      b = '0;
      if (rx_bytes.size() == 8)
        for (int i = 0; i < 4; i++) begin
          b = {b[23:0], rx_bytes[i]};
          a = {a[23:0], rx_bytes[i+4]};
        end
      if (rx_cnt != 8)                    err = 3'b100;
      else if (by[3:0] != crc_ref(b, a, op)) err = 3'b010;
      else if (!(op inside {3'd0, 3'd1, 3'd4, 3'd5})) err = 3'b001;
      else                                err = 3'b000;
      rx_cnt = 0;
      rx_bytes.delete();
      if (busy) m_ov = 1'b1;
      else begin
        m_valid = 1'b1;
        m_a = a; m_b = b; m_op = op; m_err = err;
      end
    end
  endtask

  task automatic compare();
    check("req_valid", req_valid, m_valid);
    check("req_op", req_op, m_op);
    check("req_err", req_err, m_err);
    check("frame_err", frame_err, m_fe);
    check("overrun", overrun, m_ov);
    // Operands behind an err_data request are undefined.
    if (!(m_valid && m_err[2])) begin
      check("req_a", req_a, m_a);
      check("req_b", req_b, m_b);
    end
    fe_seen += int'(frame_err);
    ov_seen += int'(overrun);
  endtask

  // Called at a falling edge; drives one bit, lets the DUT sample it, then checks.
  task automatic tick(input logic s, input int kind, input logic [7:0] by);
    sin = s;
    if (rnd_ready) req_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(kind, by);
    #1 compare();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, EV_NONE, 8'h00);
  endtask

  task automatic send_frame(input bit is_cmd, input logic [7:0] by, input bit bad_stop);
    tick(1'b0, EV_NONE, 8'h00);
    tick(is_cmd, EV_NONE, 8'h00);
    for (int i = 7; i >= 0; i--) tick(by[i], EV_NONE, 8'h00);
    tick(!bad_stop, bad_stop ? EV_FERR : (is_cmd ? EV_CMD : EV_DATA), by);
  endtask

  task automatic send_ops(input logic [31:0] b, input logic [31:0] a);
    for (int i = 3; i >= 0; i--) send_frame(1'b0, b[8*i +: 8], 1'b0);
    for (int i = 3; i >= 0; i--) send_frame(1'b0, a[8*i +: 8], 1'b0);
  endtask

  task automatic drain();
    req_ready = 1'b1;
    idle(1);
    req_ready = 1'b0;
  endtask

  initial begin
    int          base, nd;
    logic [31:0] a2, b2, qa, qb;
    logic [2:0]  op;
    logic [3:0]  crc;

    model_reset();
    #1 compare();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // B=2, A=1, ADD, crc4 = 0xC -> command byte 0x4C.
    send_ops(32'h2, 32'h1);
    send_frame(1'b1, 8'h4C, 1'b0);
    check("t1_valid", req_valid, 1'b1);
    check("t1_a", req_a, 32'h1);
    check("t1_b", req_b, 32'h2);
    check("t1_op", req_op, 3'b100);
    check("t1_err", req_err, 3'b000);
    drain();
    check("t1_cleared", req_valid, 1'b0);

    // Seven data bytes only.
    for (int i = 0; i < 7; i++) send_frame(1'b0, 8'(i + 1), 1'b0);
    send_frame(1'b1, 8'h4C, 1'b0);
    check("t2_err_data", req_err, 3'b100);
    drain();
    send_ops(32'h2, 32'h1);
    send_frame(1'b1, 8'h4C, 1'b0);
    check("t2_recover_err", req_err, 3'b000);
    check("t2_recover_a", req_a, 32'h1);
    drain();

    // CRC off by one, then illegal op 010 with its correct crc (0x6).
    send_ops(32'h2, 32'h1);
    send_frame(1'b1, 8'h4D, 1'b0);
    check("t3_err_crc", req_err, 3'b010);
    drain();
    send_ops(32'h2, 32'h1);
    send_frame(1'b1, 8'h26, 1'b0);
    check("t3_err_op", req_err, 3'b001);
    check("t3_op", req_op, 3'b010);
    drain();

    // Stop bit 0 on DATA byte 3, then 7 more good bytes: 9 good bytes in total.
    base = fe_seen;
    send_frame(1'b0, 8'h11, 1'b0);
    send_frame(1'b0, 8'h22, 1'b0);
    send_frame(1'b0, 8'h33, 1'b1);
    check("t4_frame_err_pulses", 32'(fe_seen - base), 32'd1);
    for (int i = 0; i < 7; i++) send_frame(1'b0, 8'(8'h40 + i), 1'b0);
    send_frame(1'b1, 8'h4C, 1'b0);
    check("t4_err_data", req_err, 3'b100);
    drain();

    // Two requests back to back with req_ready low.
    base = ov_seen;
    b2 = $urandom;
    a2 = $urandom;
    send_ops(32'h2, 32'h1);
    send_frame(1'b1, 8'h4C, 1'b0);
    send_ops(b2, a2);
    send_frame(1'b1, {4'b0000, crc_ref(b2, a2, 3'b000)}, 1'b0);
    check("t5_overrun_pulses", 32'(ov_seen - base), 32'd1);
    check("t5_held_valid", req_valid, 1'b1);
    check("t5_held_a", req_a, 32'h1);
    check("t5_held_b", req_b, 32'h2);
    check("t5_held_op", req_op, 3'b100);
    drain();

    // Reset in the middle of DATA byte 5 while a request is pending.
    send_ops(32'h2, 32'h1);
    send_frame(1'b1, 8'h4C, 1'b0);
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'hA5, 1'b0);
    tick(1'b0, EV_NONE, 8'h00);
    tick(1'b0, EV_NONE, 8'h00);
    for (int i = 0; i < 3; i++) tick(1'b1, EV_NONE, 8'h00);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_valid", req_valid, 1'b0);
    check("t6_rst_a", req_a, 32'h0);
    check("t6_rst_err", req_err, 3'b000);
    compare();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_ops(32'h2, 32'h1);
    send_frame(1'b1, 8'h4C, 1'b0);
    check("t6_after_valid", req_valid, 1'b1);
    check("t6_after_a", req_a, 32'h1);
    check("t6_after_err", req_err, 3'b000);
    drain();

    // Randomized traffic, checked every cycle against the model.
    rnd_ready = 1'b1;
    repeat (120) begin
      nd = ($urandom_range(0, 9) < 7) ? 8 : int'($urandom_range(0, 10));
      for (int i = 0; i < nd; i++) begin
        send_frame(1'b0, 8'($urandom), $urandom_range(0, 19) == 0);
        idle(int'($urandom_range(0, 2)));
      end
      op = 3'($urandom);
      crc = 4'($urandom);
      if (rx_bytes.size() == 8 && $urandom_range(0, 3) != 0) begin
        qa = '0;
        qb = '0;
        for (int i = 0; i < 4; i++) begin
          qb = {qb[23:0], rx_bytes[i]};
          qa = {qa[23:0], rx_bytes[i+4]};
        end
        crc = crc_ref(qb, qa, op);
      end
      send_frame(1'b1, {1'b0, op, crc}, $urandom_range(0, 19) == 0);
      idle(int'($urandom_range(0, 3)));
    end
    rnd_ready = 1'b0;
    req_ready = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
